// File: rtl/feed_forward_input_layer_scheduler.sv
// rtl/feed_forward_input_layer_scheduler.sv - input-layer node sequencer (optional watchdog: SCHED_WATCHDOG_TIMEOUT_EN)
module feed_forward_input_layer_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_NODES      = 64,
  parameter int ADDR_WIDTH     = 8,
  parameter int IDX_WIDTH      = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_state0,
  input  logic [DATA_WIDTH-1:0] i_state1,
  input  logic [DATA_WIDTH-1:0] i_state2,
  output logic                  o_weight_rd,
  output logic [ADDR_WIDTH-1:0] o_weight_addr,
  input  logic [DATA_WIDTH-1:0] i_weight,
  output logic                  o_node_valid,
  output logic [DATA_WIDTH-1:0] o_node_data,
  output logic [DATA_WIDTH-1:0] o_node_weight,
  input  logic                  i_result_valid,
  input  logic [DATA_WIDTH-1:0] i_result,
  output logic                  o_out_valid,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [IDX_WIDTH-1:0]  o_out_index,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(3 * NUM_NODES - 1);
  localparam logic [IDX_WIDTH:0]    NODE_COUNT = (IDX_WIDTH + 1)'(NUM_NODES);

  state_t                state;
  logic [DATA_WIDTH-1:0] st0, st1, st2;
  logic [1:0]            k;
  logic [IDX_WIDTH:0]    res_cnt;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept_result;

`ifdef SCHED_WATCHDOG_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            error_q;
  assign o_error = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign o_error = 1'b0;
`endif

  // The RAM's own output register provides the pipeline stage for the weight;
  // gate it with the pair valid so it reads as zero when no pair is offered.
  assign o_node_weight = o_node_valid ? i_weight : '0;

  // Results only count while a pass is in flight.
  assign accept_result = i_result_valid && (state == ISSUE || state == DRAIN);

  // Pick the latched state element for the address currently being read.
  always_comb begin
    sel_data = '0;
    case (k)
      2'd0:    sel_data = st0;
      2'd1:    sel_data = st1;
      default: sel_data = st2;
    endcase
  end

  // Main sequencer: start latch, weight address walk, drain wait, completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      st0           <= '0;
      st1           <= '0;
      st2           <= '0;
      k             <= 2'd0;
      o_weight_rd   <= 1'b0;
      o_weight_addr <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
`ifdef SCHED_WATCHDOG_TIMEOUT_EN
      wd_cnt        <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            st0           <= i_state0;
            st1           <= i_state1;
            st2           <= i_state2;
            k             <= 2'd0;
            o_weight_rd   <= 1'b1;
            o_weight_addr <= '0;
            o_busy        <= 1'b1;
            state         <= ISSUE;
`ifdef SCHED_WATCHDOG_TIMEOUT_EN
            wd_cnt        <= '0;
            error_q       <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          if (o_weight_addr == LAST_ADDR) begin
            o_weight_rd <= 1'b0;
            state       <= DRAIN;
          end else begin
            o_weight_addr <= o_weight_addr + 1'b1;
            k             <= (k == 2'd2) ? 2'd0 : k + 2'd1;
          end
        end
        DRAIN: begin
          if (res_cnt == NODE_COUNT) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= DONE;
          end
`ifdef SCHED_WATCHDOG_TIMEOUT_EN
          else if (!i_result_valid && wd_cnt == WD_LAST) begin
            error_q <= 1'b1;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else if (i_result_valid) begin
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pair stage: valid and input element trail the weight read by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_node_valid <= 1'b0;
      o_node_data  <= '0;
    end else begin
      o_node_valid <= o_weight_rd;
      if (o_weight_rd) begin
        o_node_data <= sel_data;
      end
    end
  end

  // Result tagging: register each accepted result with its node index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_index <= '0;
      res_cnt     <= '0;
    end else begin
      o_out_valid <= 1'b0;
      if (state == IDLE && i_start) begin
        res_cnt <= '0;
      end else if (accept_result) begin
        o_out_valid <= 1'b1;
        o_out_data  <= i_result;
        o_out_index <= res_cnt[IDX_WIDTH-1:0];
        res_cnt     <= res_cnt + 1'b1;
      end
    end
  end

endmodule
